loop_apu_engine: RTL
====================

LOOP_APU_ENGINE -- requirements
Module: loop_apu_engine

Interface
REQ-001 SHALL have parameter LOOP_DEPTH, default 8, meaning loop stack depth (power of 2, >=2).
REQ-002 SHALL have parameter NUM_APU, default 8, meaning address units (power of 2).
REQ-003 SHALL have parameters ADDR_W=18 (address/coefficient width), LANES=8 (superscalar width, power of 2) and JUMP_W=6 (jump field width).
REQ-004 SHALL have ports clk in 1, clock; reset in 1, synchronous, active-high.
REQ-005 SHALL have cfg_we in 1, cfg_apu in log2(NUM_APU), cfg_coef in LOOP_DEPTH*ADDR_W and cfg_const in ADDR_W, which load one APU's coefficients and its initial address.
REQ-006 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (0 START, 1 END, 2 QUERY, 3 CLEAR), cmd_indep in 1, cmd_iters in ADDR_W, cmd_jump in JUMP_W, cmd_name in log2(LOOP_DEPTH), cmd_apu_a in log2(NUM_APU) and cmd_apu_b in log2(NUM_APU).
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_taken out 1, rsp_jump out JUMP_W, rsp_copy out log2(LANES)+1, and rsp_addr_a, rsp_addr_b, rsp_daddr_a, rsp_daddr_b out ADDR_W each.
REQ-008 SHALL have depth out log2(LOOP_DEPTH)+1 (live stack entries), err_overflow out 1 and err_underflow out 1 (both sticky).

Function
REQ-009 SHALL implement the FSM IDLE -> EXEC -> APU -> RESP -> IDLE; the APU state is entered only by a non-final END.
REQ-010 SHALL drive cmd_ready high only in IDLE with cfg_we low; a command is accepted on cmd_valid&&cmd_ready.
REQ-011 SHALL apply cfg_we only in IDLE: coef[cfg_apu]<=cfg_coef, addr[cfg_apu]<=cfg_const; no command is accepted that cycle.
REQ-012 SHALL latch all cmd_* fields on accept; EXEC operates on the latched copy.
REQ-013 SHALL, on START, push {value=0, total=cmd_iters, indep, jump, name}; cmd_iters==0 is stored as 1; APU addresses are unchanged.
REQ-014 SHALL, on END, compute rem=total-value and step=indep?min(rem,LANES):1, then set value+=step.
REQ-015 SHALL, on END with rem<=step: pop the entry, set di=-(old value) (rewind to loop-entry address), rsp_taken=0 and rsp_jump=0.
REQ-016 SHALL, on END with rem>step: set di=+step, rsp_taken=1 and rsp_jump=the entry's jump.
REQ-017 SHALL, in APU, update every k: addr[k]+=di*coef[k][name of the ended loop], modulo 2^ADDR_W, all in one cycle.
REQ-018 SHALL, on QUERY, return rsp_addr_x=addr[apu_x] and rsp_daddr_x=coef[apu_x][top name], with rsp_copy=step computed as in REQ-014 without modifying any state.
REQ-019 SHALL, for QUERY with an empty stack, return rsp_copy=1 and rsp_daddr_*=0.
REQ-020 SHALL, on CLEAR, set depth=0 and clear both error flags; APU state is retained.
REQ-021 SHALL, on START with depth==LOOP_DEPTH, set err_overflow and leave the stack unchanged.
REQ-022 SHALL, on END with depth==0, set err_underflow and leave all state unchanged; both overflow and underflow cases still respond with rsp_taken=0.
REQ-023 SHALL hold rsp_valid and all rsp_* stable in RESP until rsp_ready; IDLE is entered on the cycle after the handshake.
REQ-024 SHALL meet these latencies from accept to rsp_valid: 2 cycles for START/QUERY/CLEAR/final END, 3 cycles for non-final END.
REQ-025 SHALL, for non-QUERY ops, return rsp_addr_* and rsp_daddr_* values computed after the op completes.

Reset
REQ-026 SHALL, on reset, enter IDLE with depth=0, both error flags=0, rsp_valid=0, all rsp_* fields=0, and all addr, coef and stack fields=0.
REQ-027 SHALL abort any in-flight command when reset is asserted mid-operation, with no response issued.

Structure
REQ-028 SHALL place the cmd_op enum and FSM state enum in the shared core package; parameters stay local.
REQ-029 SHALL implement the coefficient select (coef[k][name]) as a sub-module apu_coef_mux instanced per APU and per response port.

Verification
REQ-030 SHALL verify: START iters=3, dep; END x3 -> taken=1,1,0; addr[0] with coef j=4 goes 0->4->8->0.
REQ-031 SHALL verify: START iters=20, indep, LANES=8; QUERY -> copy=8; END -> taken=1 and step 8, then 8; third END -> copy 4 and taken=0.
REQ-032 SHALL verify: LOOP_DEPTH+1 STARTs -> err_overflow=1 and depth=LOOP_DEPTH; CLEAR -> depth=0 and flag=0.
REQ-033 SHALL verify: END on an empty stack -> err_underflow=1 and rsp_taken=0, with all addresses unchanged.
REQ-034 SHALL verify: rsp_ready held low for 5 cycles -> rsp stable and cmd_ready=0 throughout, then cmd_ready=1 on the cycle after the handshake.
REQ-035 SHALL verify: reset asserted in APU state -> no response, and depth=0 on the next cycle.

Source files
------------

// File: rtl/loop_apu_engine_pkg.sv
// Shared types for the loop/address-unit engine: command opcodes and FSM states.
package loop_apu_engine_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_END   = 2'd1,
    OP_QUERY = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_APU  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/loop_apu_engine_coef_mux.sv
// Selects one coefficient out of an APU's packed per-loop coefficient row.
module apu_coef_mux #(
  parameter int LOOP_DEPTH = 8,
  parameter int ADDR_W     = 18
) (
  input  logic [LOOP_DEPTH*ADDR_W-1:0]   coef_row,
  input  logic [$clog2(LOOP_DEPTH)-1:0]  name,
  output logic [ADDR_W-1:0]              coef
);

  localparam int NW = $clog2(LOOP_DEPTH);

  always_comb begin
    coef = '0;
    for (int i = 0; i < LOOP_DEPTH; i++) begin
      if (name == NW'(i)) coef = coef_row[i*ADDR_W +: ADDR_W];
    end
  end

endmodule

// File: rtl/loop_apu_engine.sv
// Hardware loop stack with per-loop address units: START/END/QUERY/CLEAR commands,
// address stepping on loop iteration and rewind to the loop-entry address on exit.
//
// state | meaning
// IDLE  | accepts config writes or one command
// EXEC  | applies the latched command to the stack (and final-END rewind)
// APU   | non-final END: all address units step by di*coef
// RESP  | holds the response until rsp_ready
module loop_apu_engine
  import loop_apu_engine_pkg::*;
#(
  parameter int LOOP_DEPTH = 8,
  parameter int NUM_APU    = 8,
  parameter int ADDR_W     = 18,
  parameter int LANES      = 8,
  parameter int JUMP_W     = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_APU)-1:0]       cfg_apu,
  input  logic [LOOP_DEPTH*ADDR_W-1:0]     cfg_coef,
  input  logic [ADDR_W-1:0]                cfg_const,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic                             cmd_indep,
  input  logic [ADDR_W-1:0]                cmd_iters,
  input  logic [JUMP_W-1:0]                cmd_jump,
  input  logic [$clog2(LOOP_DEPTH)-1:0]    cmd_name,
  input  logic [$clog2(NUM_APU)-1:0]       cmd_apu_a,
  input  logic [$clog2(NUM_APU)-1:0]       cmd_apu_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_taken,
  output logic [JUMP_W-1:0]                rsp_jump,
  output logic [$clog2(LANES):0]           rsp_copy,
  output logic [ADDR_W-1:0]                rsp_addr_a,
  output logic [ADDR_W-1:0]                rsp_addr_b,
  output logic [ADDR_W-1:0]                rsp_daddr_a,
  output logic [ADDR_W-1:0]                rsp_daddr_b,
  output logic [$clog2(LOOP_DEPTH):0]      depth,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  localparam int NW = $clog2(LOOP_DEPTH);
  localparam int AW = $clog2(NUM_APU);
  localparam int DW = NW + 1;
  localparam int CW = $clog2(LANES) + 1;
  localparam logic [ADDR_W-1:0] LANES_V = ADDR_W'(LANES);
  localparam logic [DW-1:0]     FULL_D  = DW'(LOOP_DEPTH);

  state_e                      state;
  cmd_op_e                     c_op;
  logic                        c_indep;
  logic [ADDR_W-1:0]           c_iters;
  logic [JUMP_W-1:0]           c_jump;
  logic [NW-1:0]               c_name;
  logic [AW-1:0]               c_apu_a, c_apu_b;
  logic [ADDR_W-1:0]           di_q;
  logic [NW-1:0]               name_q;

  logic [LOOP_DEPTH*ADDR_W-1:0] coef [NUM_APU];
  logic [ADDR_W-1:0]           addr      [NUM_APU];
  logic [ADDR_W-1:0]           coef_sel  [NUM_APU];
  logic [ADDR_W-1:0]           next_addr [NUM_APU];

  logic [ADDR_W-1:0]           stk_value [LOOP_DEPTH];
  logic [ADDR_W-1:0]           stk_total [LOOP_DEPTH];
  logic                        stk_indep [LOOP_DEPTH];
  logic [JUMP_W-1:0]           stk_jump  [LOOP_DEPTH];
  logic [NW-1:0]               stk_name  [LOOP_DEPTH];

  logic [NW-1:0]               top_idx, below_idx;
  logic [ADDR_W-1:0]           rem, step, upd_di;
  logic [NW-1:0]               upd_name, post_name;
  logic [DW-1:0]               post_depth;
  logic                        empty, full, is_final, use_next;
  logic [ADDR_W-1:0]           rsp_coef_a, rsp_coef_b;
  logic [ADDR_W-1:0]           resp_addr_a, resp_addr_b, resp_daddr_a, resp_daddr_b;

  assign cmd_ready = (state == ST_IDLE) && !cfg_we;

  assign empty     = (depth == '0);
  assign full      = (depth == FULL_D);
  assign top_idx   = depth[NW-1:0] - NW'(1);
  assign below_idx = top_idx - NW'(1);

  always_comb begin
    rem  = stk_total[top_idx] - stk_value[top_idx];
    step = ADDR_W'(1);
    if (stk_indep[top_idx]) step = (rem < LANES_V) ? rem : LANES_V;
    is_final = (rem <= step);
  end

  // APU state replays the registered step; EXEC only ever rewinds (final END).
  assign upd_di   = (state == ST_APU) ? di_q   : ('0 - stk_value[top_idx]);
  assign upd_name = (state == ST_APU) ? name_q : stk_name[top_idx];
  assign use_next = (state == ST_APU) ||
                    ((state == ST_EXEC) && (c_op == OP_END) && !empty && is_final);

  for (genvar k = 0; k < NUM_APU; k++) begin : g_apu
    apu_coef_mux #(.LOOP_DEPTH(LOOP_DEPTH), .ADDR_W(ADDR_W)) u_mux (
      .coef_row (coef[k]),
      .name     (upd_name),
      .coef     (coef_sel[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_APU; k++) next_addr[k] = addr[k] + upd_di * coef_sel[k];
  end

  // Stack top as it will look once the current op has completed.
  always_comb begin
    post_depth = depth;
    post_name  = stk_name[top_idx];
    if (state == ST_EXEC) begin
      case (c_op)
        OP_START: if (!full) begin
          post_depth = depth + DW'(1);
          post_name  = c_name;
        end
        OP_END: if (!empty && is_final) begin
          post_depth = depth - DW'(1);
          post_name  = stk_name[below_idx];
        end
        OP_CLEAR: post_depth = '0;
        default: ;
      endcase
    end
  end

  apu_coef_mux #(.LOOP_DEPTH(LOOP_DEPTH), .ADDR_W(ADDR_W)) u_rsp_mux_a (
    .coef_row (coef[c_apu_a]),
    .name     (post_name),
    .coef     (rsp_coef_a)
  );

  apu_coef_mux #(.LOOP_DEPTH(LOOP_DEPTH), .ADDR_W(ADDR_W)) u_rsp_mux_b (
    .coef_row (coef[c_apu_b]),
    .name     (post_name),
    .coef     (rsp_coef_b)
  );

  assign resp_addr_a  = use_next ? next_addr[c_apu_a] : addr[c_apu_a];
  assign resp_addr_b  = use_next ? next_addr[c_apu_b] : addr[c_apu_b];
  assign resp_daddr_a = (post_depth == '0) ? '0 : rsp_coef_a;
  assign resp_daddr_b = (post_depth == '0) ? '0 : rsp_coef_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_taken     <= 1'b0;
      rsp_jump      <= '0;
      rsp_copy      <= '0;
      rsp_addr_a    <= '0;
      rsp_addr_b    <= '0;
      rsp_daddr_a   <= '0;
      rsp_daddr_b   <= '0;
      c_op          <= OP_START;
      c_indep       <= 1'b0;
      c_iters       <= '0;
      c_jump        <= '0;
      c_name        <= '0;
      c_apu_a       <= '0;
      c_apu_b       <= '0;
      di_q          <= '0;
      name_q        <= '0;
      for (int k = 0; k < NUM_APU; k++) begin
        addr[k] <= '0;
        coef[k] <= '0;
      end
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        stk_value[i] <= '0;
        stk_total[i] <= '0;
        stk_indep[i] <= 1'b0;
        stk_jump[i]  <= '0;
        stk_name[i]  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_we) begin
            coef[cfg_apu] <= cfg_coef;
            addr[cfg_apu] <= cfg_const;
          end else if (cmd_valid) begin
            c_op    <= cmd_op_e'(cmd_op);
            c_indep <= cmd_indep;
            c_iters <= cmd_iters;
            c_jump  <= cmd_jump;
            c_name  <= cmd_name;
            c_apu_a <= cmd_apu_a;
            c_apu_b <= cmd_apu_b;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid   <= 1'b1;
          rsp_taken   <= 1'b0;
          rsp_jump    <= '0;
          rsp_copy    <= '0;
          rsp_addr_a  <= resp_addr_a;
          rsp_addr_b  <= resp_addr_b;
          rsp_daddr_a <= resp_daddr_a;
          rsp_daddr_b <= resp_daddr_b;
          state       <= ST_RESP;
          case (c_op)
            OP_START: begin
              if (full) err_overflow <= 1'b1;
              else begin
                stk_value[depth[NW-1:0]] <= '0;
                stk_total[depth[NW-1:0]] <= (c_iters == '0) ? ADDR_W'(1) : c_iters;
                stk_indep[depth[NW-1:0]] <= c_indep;
                stk_jump[depth[NW-1:0]]  <= c_jump;
                stk_name[depth[NW-1:0]]  <= c_name;
                depth <= depth + DW'(1);
              end
            end
            OP_END: begin
              if (empty) err_underflow <= 1'b1;
              else begin
                rsp_copy <= step[CW-1:0];
                if (is_final) begin
                  depth <= depth - DW'(1);
                  for (int k = 0; k < NUM_APU; k++) addr[k] <= next_addr[k];
                end else begin
                  stk_value[top_idx] <= stk_value[top_idx] + step;
                  di_q      <= step;
                  name_q    <= stk_name[top_idx];
                  rsp_taken <= 1'b1;
                  rsp_jump  <= stk_jump[top_idx];
                  rsp_valid <= 1'b0;
                  state     <= ST_APU;
                end
              end
            end
            OP_QUERY: rsp_copy <= empty ? CW'(1) : step[CW-1:0];
            OP_CLEAR: begin
              depth         <= '0;
              err_overflow  <= 1'b0;
              err_underflow <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_APU: begin
          for (int k = 0; k < NUM_APU; k++) addr[k] <= next_addr[k];
          rsp_addr_a  <= resp_addr_a;
          rsp_addr_b  <= resp_addr_b;
          rsp_daddr_a <= resp_daddr_a;
          rsp_daddr_b <= resp_daddr_b;
          rsp_valid   <= 1'b1;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
